// File: rtl/tetris_pkg.sv
// Shared constants, coordinate widths and enums for the falling-piece controller.
// Latency: none (declarations only).
// Backpressure: none.
package tetris_pkg;

   // HID usage codes for the arrow keys
   localparam logic [7:0] KEY_LEFT  = 8'h50;
   localparam logic [7:0] KEY_RIGHT = 8'h4F;
   localparam logic [7:0] KEY_UP    = 8'h52;
   localparam logic [7:0] KEY_DOWN  = 8'h51;

   // Playfield size; the board block owns the actual bounds checks
   localparam int BOARD_W = 10;
   localparam int BOARD_H = 20;

   // Two's complement box coordinates: x in -3..9, y in -3..19
   localparam int X_W   = 5;
   localparam int Y_W   = 6;
   localparam int CNT_W = 8;

   // Kind of move currently under collision query
   typedef enum logic [1:0] {
      REQ_ROT,
      REQ_LEFT,
      REQ_RIGHT,
      REQ_DOWN
   } req_kind_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SPAWN,
      ST_SPAWNCHK,
      ST_READY,
      ST_QUERY,
      ST_LANDED
   } state_t;

   // A key event is a change to a non-zero keycode; held keys never repeat
   function automatic logic key_event(input logic [7:0] cur, input logic [7:0] prev);
      return (cur != prev) && (cur != 8'h00);
   endfunction

endpackage

// File: rtl/rotate4x4_cw.sv
// Clockwise rotation of a 4x4 bitmap, bit r*4+c is row r, column c.
// Latency: purely combinational.
// Backpressure: none.
module rotate4x4_cw (
   input  logic [15:0] shape_in,
   output logic [15:0] shape_out
);

   // new[r][c] = old[3-c][r]
   always_comb begin
      shape_out = '0;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            shape_out[r*4+c] = shape_in[(3-c)*4+r];
         end
      end
   end

endmodule

// File: rtl/falling_piece_ctrl.sv
// Active tetromino owner: spawn, gravity, player moves, landing lock.
// Latency: one collision query per move; commit on the cycle after query_ack.
// Backpressure: query_req held with a stable candidate until the board acks.
module falling_piece_ctrl
   import tetris_pkg::*;
#(
   parameter int SPAWN_X        = 3,
   parameter int GRAVITY_FRAMES = 30,
   parameter int SOFT_FRAMES    = 3
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        frame_tick,
   input  logic [7:0]  keycode,
   input  logic [15:0] blockstate_new,
   input  logic        resetBlocks,
   input  logic        Pause,
   output logic [4:0]  piece_x,
   output logic [5:0]  piece_y,
   output logic [15:0] piece_shape,
   output logic        piece_active,
   output logic        query_req,
   output logic [4:0]  query_x,
   output logic [5:0]  query_y,
   output logic [15:0] query_shape,
   input  logic        query_ack,
   input  logic        query_collide,
   output logic        lock_valid,
   output logic        hitbottom,
   output logic        endgame
);

   localparam logic [CNT_W-1:0] GRAV_LAST = CNT_W'(GRAVITY_FRAMES - 1);
   localparam logic [CNT_W-1:0] SOFT_LAST = CNT_W'(SOFT_FRAMES - 1);
   localparam logic [X_W-1:0]   SPAWN_XV  = X_W'(SPAWN_X);

   state_t state, state_nxt;

   logic [X_W-1:0]   px, qx, cand_x;
   logic [Y_W-1:0]   py, qy, cand_y;
   logic [15:0]      pshape, qshape, cand_shape, rot_shape;
   logic             active_r;
   req_kind_t        qkind, sel_kind;
   logic [CNT_W-1:0] gcount, period_last;
   logic             pend_left, pend_right, pend_rot, pend_down, any_pend;
   logic [7:0]       last_key;
   logic             key_evt;
   logic             req_q, ack_ok;
   logic             lock_r, hit_r, end_r;
   logic             move_en;

   rotate4x4_cw u_rot (
      .shape_in  (pshape),
      .shape_out (rot_shape)
   );

   // An ack only counts once the request has been visible for a full cycle,
   // so a late ack belonging to an abandoned query cannot complete a new one.
   assign ack_ok   = query_ack && query_req && req_q;
   assign key_evt  = key_event(keycode, last_key);
   assign any_pend = pend_rot | pend_left | pend_right | pend_down;
   assign period_last = (keycode == KEY_DOWN) ? SOFT_LAST : GRAV_LAST;
   assign move_en  = (state == ST_READY) || (state == ST_QUERY);

   // Pick the highest-priority pending move and build its candidate
   always_comb begin
      sel_kind   = REQ_DOWN;
      cand_x     = px;
      cand_y     = py;
      cand_shape = pshape;
      if (pend_rot) begin
         sel_kind   = REQ_ROT;
         cand_shape = rot_shape;
      end else if (pend_left) begin
         sel_kind = REQ_LEFT;
         cand_x   = px - X_W'(1);
      end else if (pend_right) begin
         sel_kind = REQ_RIGHT;
         cand_x   = px + X_W'(1);
      end else begin
         sel_kind = REQ_DOWN;
         cand_y   = py + Y_W'(1);
      end
   end

   // State register
   always_ff @(posedge Clk) begin
      if (Reset) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   // Next-state logic; a spawn request overrides everything
   always_comb begin
      state_nxt = state;
      if (resetBlocks) begin
         state_nxt = ST_SPAWN;
      end else begin
         case (state)
            ST_IDLE:     state_nxt = ST_IDLE;
            ST_SPAWN:    state_nxt = ST_SPAWNCHK;
            ST_SPAWNCHK: if (ack_ok) state_nxt = query_collide ? ST_IDLE : ST_READY;
            ST_READY:    if (!Pause && any_pend) state_nxt = ST_QUERY;
            ST_QUERY:    if (ack_ok) state_nxt = (query_collide && qkind == REQ_DOWN) ? ST_LANDED : ST_READY;
            ST_LANDED:   state_nxt = ST_LANDED;
            default:     state_nxt = ST_IDLE;
         endcase
      end
   end

   // Output decode: the query port is live only while checking a spawn or a move
   always_comb begin
      query_req = 1'b0;
      case (state)
         ST_SPAWNCHK, ST_QUERY: query_req = 1'b1;
         default:               query_req = 1'b0;
      endcase
   end

   // Piece, candidate, pending-move and gravity datapath
   always_ff @(posedge Clk) begin
      if (Reset) begin
         px         <= '0;
         py         <= '0;
         pshape     <= '0;
         active_r   <= 1'b0;
         qx         <= '0;
         qy         <= '0;
         qshape     <= '0;
         qkind      <= REQ_ROT;
         gcount     <= '0;
         pend_left  <= 1'b0;
         pend_right <= 1'b0;
         pend_rot   <= 1'b0;
         pend_down  <= 1'b0;
         last_key   <= '0;
         req_q      <= 1'b0;
         lock_r     <= 1'b0;
         hit_r      <= 1'b0;
         end_r      <= 1'b0;
      end else begin
         lock_r   <= 1'b0;
         hit_r    <= 1'b0;
         end_r    <= 1'b0;
         last_key <= keycode;
         req_q    <= query_req && !resetBlocks;

         if (resetBlocks) begin
            active_r   <= 1'b0;
            gcount     <= '0;
            pend_left  <= 1'b0;
            pend_right <= 1'b0;
            pend_rot   <= 1'b0;
            pend_down  <= 1'b0;
         end else begin
            case (state)
               ST_SPAWN: begin
                  px     <= SPAWN_XV;
                  py     <= '0;
                  pshape <= blockstate_new;
                  qx     <= SPAWN_XV;
                  qy     <= '0;
                  qshape <= blockstate_new;
                  gcount <= '0;
               end
               ST_SPAWNCHK: begin
                  if (ack_ok) begin
                     active_r <= !query_collide;
                     end_r    <= query_collide;
                  end
               end
               ST_READY: begin
                  if (!Pause && any_pend) begin
                     qkind  <= sel_kind;
                     qx     <= cand_x;
                     qy     <= cand_y;
                     qshape <= cand_shape;
                  end
               end
               ST_QUERY: begin
                  if (ack_ok) begin
                     if (!query_collide) begin
                        px     <= qx;
                        py     <= qy;
                        pshape <= qshape;
                     end else if (qkind == REQ_DOWN) begin
                        lock_r <= 1'b1;
                        hit_r  <= 1'b1;
                     end
                     case (qkind)
                        REQ_ROT:   pend_rot   <= 1'b0;
                        REQ_LEFT:  pend_left  <= 1'b0;
                        REQ_RIGHT: pend_right <= 1'b0;
                        default:   pend_down  <= 1'b0;
                     endcase
                  end
               end
               default: ;
            endcase

            // New events come after the service clear so a fresh press is never lost
            if (move_en) begin
               if (Pause) begin
                  pend_left  <= 1'b0;
                  pend_right <= 1'b0;
                  pend_rot   <= 1'b0;
                  pend_down  <= 1'b0;
               end else begin
                  if (frame_tick) begin
                     if (gcount >= period_last) begin
                        gcount    <= '0;
                        pend_down <= 1'b1;
                     end else begin
                        gcount <= gcount + CNT_W'(1);
                     end
                  end
                  if (key_evt) begin
                     if (keycode == KEY_LEFT)  pend_left  <= 1'b1;
                     if (keycode == KEY_RIGHT) pend_right <= 1'b1;
                     if (keycode == KEY_UP)    pend_rot   <= 1'b1;
                  end
               end
            end
         end
      end
   end

   assign piece_x      = px;
   assign piece_y      = py;
   assign piece_shape  = pshape;
   assign piece_active = active_r;
   assign query_x      = qx;
   assign query_y      = qy;
   assign query_shape  = qshape;
   assign lock_valid   = lock_r;
   assign hitbottom    = hit_r;
   assign endgame      = end_r;

endmodule
